mm_axis_bridge: RTL and testbench

MM_AXIS_BRIDGE -- requirements
Module: mm_axis_bridge

---
 rtl/mm_axis_bridge.sv | 188 ++++++++++++++++++
 tb/tb_mm_axis_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_axis_bridge.sv
// AXI4 burst reader that streams a linear memory region out as AXI-Stream, splitting at 4 KB / 256-beat limits.
// Build option MM_AXIS_BRIDGE_SKID_EN inserts a registered 2-entry skid buffer between R and the stream.
module mm_axis_bridge #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ADDR_WIDTH = 34,
    parameter int LEN_WIDTH  = 16,
    parameter int ID_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  err
);

    localparam int SIZE = $clog2(KEEP_WIDTH);
    localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

    typedef enum logic [1:0] {IDLE, AR, RDATA} state_t;

    state_t                state, state_nxt;
    logic                  live;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [8:0]            burst_q;
    logic [7:0]            arlen_q;
    logic                  err_q;

    logic                  cmd_fire, cmd_go, r_fire, r_done, last_burst, load;
    logic [ADDR_WIDTH-1:0] cmd_addr_al, addr_nxt, load_addr;
    logic [LEN_WIDTH-1:0]  rem_nxt, load_rem;
    logic [8:0]            load_burst;
    logic                  unused_rid;

    // Beats for one burst: min(remaining, 256, beats left before the next 4 KB page).
    function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [LEN_WIDTH-1:0]  r);
        logic [12:0]   to_4k;
        logic [CW-1:0] lim;
        to_4k = (13'd4096 - {1'b0, a[11:0]}) >> SIZE;
        lim   = CW'(to_4k);
        if (lim > CW'(256)) lim = CW'(256);
        if (CW'(r) < lim)   lim = CW'(r);
        return 9'(lim);
    endfunction

    assign m_axi_arid    = '0;
    assign m_axi_arsize  = 3'(SIZE);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = arlen_q;
    assign m_axis_tkeep  = '1;
    assign err           = err_q;
    assign unused_rid    = ^m_axi_rid;

    assign cmd_fire    = cmd_valid && cmd_ready;
    assign cmd_go      = cmd_fire && (cmd_len != '0);
    assign r_fire      = m_axi_rvalid && m_axi_rready;
    assign r_done      = r_fire && m_axi_rlast;
    assign last_burst  = (rem_q == LEN_WIDTH'(burst_q));
    assign cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(KEEP_WIDTH - 1);
    assign addr_nxt    = addr_q + (ADDR_WIDTH'(burst_q) << SIZE);
    assign rem_nxt     = rem_q - LEN_WIDTH'(burst_q);

    // A fresh command and a follow-on burst share one burst-size calculation.
    always_comb begin
        load       = cmd_go || (r_done && !last_burst);
        load_addr  = cmd_go ? cmd_addr_al : addr_nxt;
        load_rem   = cmd_go ? cmd_len : rem_nxt;
        load_burst = burst_beats(load_addr, load_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first keeps every path assigned, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_go) state_nxt = AR;
            AR:      if (m_axi_arready) state_nxt = RDATA;
            RDATA:   if (r_done) state_nxt = last_burst ? IDLE : AR;
            default: state_nxt = IDLE;
        endcase
    end

    // live holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live    <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            burst_q <= '0;
            arlen_q <= '0;
            err_q   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (load) begin
                addr_q  <= load_addr;
                rem_q   <= load_rem;
                burst_q <= load_burst;
                arlen_q <= 8'(load_burst - 9'd1);
            end
            if (cmd_fire)                        err_q <= 1'b0;
            else if (r_fire && m_axi_rresp != 2'b00) err_q <= 1'b1;
        end
    end

`ifdef MM_AXIS_BRIDGE_SKID_EN
    logic [DATA_WIDTH-1:0] skid_data [2];
    logic [1:0]            skid_last;
    logic                  skid_wr, skid_rd, t_fire;
    logic [1:0]            skid_cnt;

    assign t_fire = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_wr   <= 1'b0;
            skid_rd   <= 1'b0;
            skid_cnt  <= 2'd0;
            skid_last <= 2'b00;
        end else begin
            if (r_fire) begin
                skid_wr            <= ~skid_wr;
                skid_last[skid_wr] <= m_axi_rlast && last_burst;
            end
            if (t_fire) skid_rd <= ~skid_rd;
            skid_cnt <= skid_cnt + 2'(r_fire) - 2'(t_fire);
        end
    end

    // NOTE: payload storage has no reset; skid_cnt alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (r_fire) skid_data[skid_wr] <= m_axi_rdata;
    end
`endif

    always_comb begin
        cmd_ready     = live && (state == IDLE);
        m_axi_arvalid = (state == AR);
`ifdef MM_AXIS_BRIDGE_SKID_EN
        m_axi_rready  = (state == RDATA) && (skid_cnt != 2'd2);
        m_axis_tvalid = (skid_cnt != 2'd0);
        m_axis_tdata  = skid_data[skid_rd];
        m_axis_tlast  = (skid_cnt != 2'd0) && skid_last[skid_rd];
        busy          = (state != IDLE) || (skid_cnt != 2'd0);
`else
        m_axi_rready  = (state == RDATA) && m_axis_tready;
        m_axis_tvalid = (state == RDATA) && m_axi_rvalid;
        m_axis_tdata  = m_axi_rdata;
        m_axis_tlast  = (state == RDATA) && m_axi_rvalid && m_axi_rlast && last_burst;
        busy          = (state != IDLE);
`endif
    end

endmodule

// File: tb/tb_mm_axis_bridge.sv
// Scoreboard bench for mm_axis_bridge: a reference model queues expected AR bursts and stream beats per command;
// negedge monitors compare whatever the DUT presents against those queues.
module tb_mm_axis_bridge;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int AW = 34;
    localparam int LW = 16;
    localparam int IW = 6;
`ifdef MM_AXIS_BRIDGE_SKID_EN
    localparam int OCC_MAX = 2;
`else
    localparam int OCC_MAX = 0;
`endif

    logic          clk, rst_n;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          cmd_valid, cmd_ready;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid, m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic          busy, err;

    mm_axis_bridge #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .err(err)
    );

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] len; } ar_t;

    beat_t exp_q[$];
    ar_t   ar_exp[$];
    ar_t   r_q[$];
    beat_t eb;
    ar_t   ea, rb;

    int checks = 0, failures = 0;
    int ar_cnt = 0, t_beats = 0, t_lasts = 0, r_cnt = 0;
    int occ = 0, max_occ = 0;
    int err_at = -1;
    int r_beat = 0, r_len = 0;
    logic [AW-1:0] r_addr;
    logic [31:0]   data_seed;
    logic r_active = 1'b0, r_fire_s = 1'b0, t_fire_s;
    logic rand_mode = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents are a pure function of the beat address.
    function automatic logic [DW-1:0] data_for(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++)
            d[k*32 +: 32] = (a[31:0] * 32'h9E3779B1) ^ (32'(k) * 32'h7F4A7C15) ^ {30'd0, a[33:32]} ^ data_seed;
        return d;
    endfunction

    // Reference model: expected bursts and beats for one command.
    task automatic model_push(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] b;
        int r;
        b = addr & ~AW'(KW - 1);
        r = len;
        for (int i = 0; i < len; i++)
            exp_q.push_back('{data: data_for(b + AW'(i * KW)), last: (i == len - 1)});
        while (r > 0) begin
            int n;
            n = (4096 - int'(b[11:0])) / KW;
            if (n > 256) n = 256;
            if (r < n) n = r;
            ar_exp.push_back('{addr: b, len: 8'(n - 1)});
            b = b + AW'(n * KW);
            r = r - n;
        end
    endtask

    task automatic issue(input logic [AW-1:0] addr, input int len);
        int n;
        n = 0;
        cmd_addr  = addr;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        if (cmd_ready) model_push(addr, len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0 || ar_exp.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_busy_low"}, busy, 1'b0);
        check({name, "_drained"}, exp_q.size() + ar_exp.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
        check({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
        check({tag, "_araddr"}, m_axi_araddr, 0);
        check({tag, "_arlen"}, m_axi_arlen, 0);
        check({tag, "_rready"}, m_axi_rready, 1'b0);
        check({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_tlast"}, m_axis_tlast, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    // Monitors: AR and stream handshakes compared against the model queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            r_fire_s = 1'b0;
            occ      = 0;
        end else begin
            r_fire_s = m_axi_rvalid && m_axi_rready;
            t_fire_s = m_axis_tvalid && m_axis_tready;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_cnt++;
                check("ar_single_outstanding", r_active || (r_q.size() != 0), 1'b0);
                check("ar_expected", ar_exp.size() != 0, 1'b1);
                if (ar_exp.size() != 0) begin
                    ea = ar_exp.pop_front();
                    check("araddr", m_axi_araddr, ea.addr);
                    check("arlen", m_axi_arlen, ea.len);
                end
                r_q.push_back('{addr: m_axi_araddr, len: m_axi_arlen});
            end
            if (t_fire_s) begin
                t_beats++;
                if (m_axis_tlast) t_lasts++;
                check("tkeep", m_axis_tkeep, {KW{1'b1}});
                check("beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    eb = exp_q.pop_front();
                    check("tdata", m_axis_tdata, eb.data);
                    check("tlast", m_axis_tlast, eb.last);
                end
            end
            if (r_fire_s) r_cnt++;
            occ = occ + int'(r_fire_s) - int'(t_fire_s);
            if (occ > max_occ) max_occ = occ;
        end
    end

    // AXI slave: serves one queued burst at a time; rvalid stays up until accepted.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            r_active      = 1'b0;
            r_q.delete();
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_rresp   = 2'd0;
            m_axi_arready = 1'b0;
        end else begin
            if (r_fire_s) begin
                m_axi_rvalid = 1'b0;
                if (r_beat == r_len) r_active = 1'b0;
                else                 r_beat++;
            end
            if (!r_active && r_q.size() != 0) begin
                rb       = r_q.pop_front();
                r_addr   = rb.addr;
                r_len    = int'(rb.len);
                r_beat   = 0;
                r_active = 1'b1;
            end
            if (r_active && !m_axi_rvalid && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata  = data_for(r_addr + AW'(r_beat * KW));
                m_axi_rlast  = (r_beat == r_len);
                m_axi_rresp  = (r_cnt == err_at) ? 2'd2 : 2'd0;
                m_axi_rid    = IW'($urandom);
            end
            m_axi_arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ar0, tb0, tl0, n;
        data_seed     = $urandom;
        rst_n         = 1'b0;
        cmd_addr      = '0;
        cmd_len       = '0;
        cmd_valid     = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rresp   = 2'd0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axis_tready = 1'b1;
        #2;
        check_reset("por");
        check("arid", m_axi_arid, 0);
        check("arsize", m_axi_arsize, 3'd6);
        check("arburst", m_axi_arburst, 2'b01);
        check("arlock", m_axi_arlock, 1'b0);
        check("arcache", m_axi_arcache, 4'd0);
        check("arprot", m_axi_arprot, 3'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("cmd_ready_at_release", cmd_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("cmd_ready_first_edge", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        ar0 = ar_cnt; tb0 = t_beats; tl0 = t_lasts;
        issue(34'h1000, 4);
        wait_idle("basic", 200);
        check("basic_ar_count", ar_cnt - ar0, 1);
        check("basic_beats", t_beats - tb0, 4);
        check("basic_tlast_count", t_lasts - tl0, 1);

        ar0 = ar_cnt; tl0 = t_lasts;
        issue(34'hFC0, 4);
        wait_idle("cross_4k", 200);
        check("cross_4k_ar_count", ar_cnt - ar0, 2);
        check("cross_4k_tlast_count", t_lasts - tl0, 1);

        ar0 = ar_cnt; tb0 = t_beats; tl0 = t_lasts;
        issue(34'h0, 600);
        wait_idle("long", 5000);
        check("long_ar_count", ar_cnt - ar0, 10);
        check("long_beats", t_beats - tb0, 600);
        check("long_tlast_count", t_lasts - tl0, 1);

        ar0 = ar_cnt; tb0 = t_beats;
        issue(34'h3_FFFF_FF80, 4);
        wait_idle("wrap", 200);
        check("wrap_ar_count", ar_cnt - ar0, 2);

        ar0 = ar_cnt; tb0 = t_beats;
        issue(34'h5000, 0);
        repeat (10) @(negedge clk);
        check("zero_len_no_ar", ar_cnt - ar0, 0);
        check("zero_len_no_beats", t_beats - tb0, 0);
        check("zero_len_busy", busy, 1'b0);
        check("zero_len_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        rand_mode = 1'b1;
        tb0 = t_beats; tl0 = t_lasts;
        issue(34'h7000, 16);
        wait_idle("stall16", 2000);
        check("stall16_beats", t_beats - tb0, 16);
        check("stall16_tlast_count", t_lasts - tl0, 1);

        for (int i = 0; i < 6; i++) begin
            issue({2'($urandom_range(0, 3)), 32'($urandom)}, $urandom_range(1, 300));
            if (i % 2 == 0) wait_idle("random", 20000);
        end
        wait_idle("random_tail", 20000);

        rand_mode = 1'b0;
        err_at = r_cnt + 1;
        issue(34'h3000, 3);
        wait_idle("rresp_err", 200);
        check("err_sticky", err, 1'b1);
        err_at = -1;
        issue(34'h4000, 2);
        check("err_cleared_on_cmd", err, 1'b0);
        wait_idle("after_err", 200);

        rand_mode = 1'b1;
        err_at = r_cnt;
        tb0 = t_beats;
        issue(34'h2000, 64);
        n = 0;
        while (t_beats < tb0 + 3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("pre_reset_progress", t_beats >= tb0 + 3, 1'b1);
        check("pre_reset_err", err, 1'b1);
        check("pre_reset_busy", busy, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_rst");
        exp_q.delete();
        ar_exp.delete();
        err_at = -1;
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check("cmd_ready_after_rst", cmd_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("cmd_ready_one_cycle", cmd_ready, 1'b1);
        @(posedge clk);
        #1;

        rand_mode = 1'b0;
        tb0 = t_beats;
        issue(34'h8000, 8);
        wait_idle("recovery", 300);
        check("recovery_beats", t_beats - tb0, 8);

        check("rready_vs_buffer_space", max_occ <= OCC_MAX, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
